// File: rtl/alu_dispatch_sequencer_if.sv
// Decode-to-ALU dispatch bus: instruction handshake, unit issue/done and register-file write.
// master = decode/ALU/regfile side, slave = sequencer.
interface alu_dispatch_sequencer_if;
   logic          instr_valid;
   logic          instr_ready;
   logic [6:0]    opcode;
   logic [4:0]    rd_addr_in;
   logic [31:0]   pc_in;
   logic [31:0]   imm_in;
   logic [31:0]   rs1_value_in;
   logic [3:0]    unit_enable;
   logic [31:0]   unit_pc;
   logic [31:0]   unit_imm;
   logic [31:0]   unit_rs1;
   logic [3:0]    unit_done;
   logic [127:0]  unit_result;
   logic          rd_we;
   logic [4:0]    rd_addr;
   logic [31:0]   rd_data;
   logic          illegal;
   logic          timeout;
   logic          busy;

   modport slave (
      input  instr_valid, opcode, rd_addr_in, pc_in, imm_in, rs1_value_in,
             unit_done, unit_result,
      output instr_ready, unit_enable, unit_pc, unit_imm, unit_rs1,
             rd_we, rd_addr, rd_data, illegal, timeout, busy
   );

   modport master (
      output instr_valid, opcode, rd_addr_in, pc_in, imm_in, rs1_value_in,
             unit_done, unit_result,
      input  instr_ready, unit_enable, unit_pc, unit_imm, unit_rs1,
             rd_we, rd_addr, rd_data, illegal, timeout, busy
   );
endinterface

// File: rtl/alu_dispatch_sequencer.sv
// Dispatches one decoded RV32I upper-imm/integer instruction to its ALU unit and writes back the result.
// Min 4 cycles per instruction; instr_ready only in IDLE, so upstream holds instr_valid while busy.
module alu_dispatch_sequencer #(
   parameter int TIMEOUT = 15
) (
   input  logic                       clk,
   input  logic                       reset_n,
   alu_dispatch_sequencer_if.slave    bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WB,
      S_ERR
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t        state_q;
   logic [1:0]    sel_q;
   logic [4:0]    rd_addr_q;
   logic [31:0]   pc_q;
   logic [31:0]   imm_q;
   logic [31:0]   rs1_q;
   logic [31:0]   rd_data_q;
   logic [3:0]    unit_enable_q;
   logic          rd_we_q;
   logic          illegal_q;
   logic          timeout_q;
   logic [7:0]    cnt_q;

   logic          dec_vld;
   logic [1:0]    dec_sel;

   always_comb begin
      dec_vld = 1'b1;
      dec_sel = 2'd0;
      case (bus.opcode)
         7'h37:   dec_sel = 2'd0;
         7'h17:   dec_sel = 2'd1;
         7'h13:   dec_sel = 2'd2;
         7'h33:   dec_sel = 2'd3;
         default: dec_vld = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         sel_q         <= 2'd0;
         rd_addr_q     <= 5'd0;
         pc_q          <= 32'd0;
         imm_q         <= 32'd0;
         rs1_q         <= 32'd0;
         rd_data_q     <= 32'd0;
         unit_enable_q <= 4'd0;
         rd_we_q       <= 1'b0;
         illegal_q     <= 1'b0;
         timeout_q     <= 1'b0;
         cnt_q         <= 8'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.instr_valid) begin
                  sel_q     <= dec_sel;
                  rd_addr_q <= bus.rd_addr_in;
                  pc_q      <= bus.pc_in;
                  imm_q     <= bus.imm_in;
                  rs1_q     <= bus.rs1_value_in;
                  if (dec_vld) begin
                     unit_enable_q <= 4'b0001 << dec_sel;
                     state_q       <= S_ISSUE;
                  end else begin
                     illegal_q <= 1'b1;
                     state_q   <= S_ERR;
                  end
               end
            end
            S_ISSUE: begin
               unit_enable_q <= 4'd0;
               cnt_q         <= 8'd0;
               state_q       <= S_WAIT;
            end
            S_WAIT: begin
               // A done in the final WAIT cycle still takes priority over the abort.
               if (bus.unit_done[sel_q]) begin
                  rd_data_q <= bus.unit_result[{sel_q, 5'd0} +: 32];
                  rd_we_q   <= (rd_addr_q != 5'd0);
                  state_q   <= S_WB;
               end else if (cnt_q == CNT_LAST) begin
                  timeout_q <= 1'b1;
                  state_q   <= S_ERR;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_WB: begin
               rd_we_q <= 1'b0;
               state_q <= S_IDLE;
            end
            S_ERR: begin
               illegal_q <= 1'b0;
               timeout_q <= 1'b0;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.instr_ready = (state_q == S_IDLE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.unit_enable = unit_enable_q;
   assign bus.unit_pc     = pc_q;
   assign bus.unit_imm    = imm_q;
   assign bus.unit_rs1    = rs1_q;
   assign bus.rd_we       = rd_we_q;
   assign bus.rd_addr     = rd_addr_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.illegal     = illegal_q;
   assign bus.timeout     = timeout_q;

endmodule
